// File: rtl/max_prio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : max_prio_arbiter
//  Description : Seven-way priority arbiter for one shared resource. The
//                highest effective priority (priority plus scaled age) wins;
//                ties rotate round-robin. A grant is held until done or a
//                hold timeout, followed by one dead cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module max_prio_arbiter #(
    parameter int MAX_HOLD  = 16,
    parameter int AGE_SHIFT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] req,
    input  logic [7:0] prio0,
    input  logic [7:0] prio1,
    input  logic [7:0] prio2,
    input  logic [7:0] prio3,
    input  logic [7:0] prio4,
    input  logic [7:0] prio5,
    input  logic [7:0] prio6,
    input  logic       done,
    output logic [6:0] grant,
    output logic [2:0] grant_id,
    output logic [7:0] grant_prio,
    output logic       busy,
    output logic       timeout
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GRANT = 2'd1;
    localparam logic [1:0] c_GAP   = 2'd2;

    // Last hold count before the grant is forcibly revoked
    localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [1:0] r_state;
    logic [2:0] r_rr_ptr;
    logic [7:0] r_hold_cnt;
    logic [3:0] r_age [0:6];

    logic [6:0] r_grant;
    logic [2:0] r_grant_id;
    logic [7:0] r_grant_prio;
    logic       r_busy;
    logic       r_timeout;

    logic [7:0] w_prio [0:6];
    logic [7:0] w_eff  [0:6];
    logic [7:0] w_max;
    logic [2:0] w_win;
    logic [3:0] w_idx;
    logic       w_found;

    assign w_prio[0] = prio0;
    assign w_prio[1] = prio1;
    assign w_prio[2] = prio2;
    assign w_prio[3] = prio3;
    assign w_prio[4] = prio4;
    assign w_prio[5] = prio5;
    assign w_prio[6] = prio6;

    // Effective priority: 9-bit sum of priority and shifted age, saturated to 8 bits
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_eff
            logic [8:0] w_sum;
            assign w_sum     = {1'b0, w_prio[gi]} + ({5'd0, r_age[gi]} << AGE_SHIFT);
            assign w_eff[gi] = w_sum[8] ? 8'hFF : w_sum[7:0];
        end
    endgenerate

    // Largest effective priority among the current candidates
    always_comb begin
        w_max = 8'd0;
        for (int i = 0; i < 7; i++) begin
            if (req[i] && (w_eff[i] > w_max)) begin
                w_max = w_eff[i];
            end
        end
    end

    // First candidate holding the maximum, scanning upward from rr_ptr modulo 7
    always_comb begin
        w_win   = 3'd0;
        w_found = 1'b0;
        w_idx   = 4'd0;
        for (int k = 0; k < 7; k++) begin
            w_idx = {1'b0, r_rr_ptr} + 4'(k);
            if (w_idx >= 4'd7) begin
                w_idx = w_idx - 4'd7;
            end
            if (!w_found && req[w_idx[2:0]] && (w_eff[w_idx[2:0]] == w_max)) begin
                w_win   = w_idx[2:0];
                w_found = 1'b1;
            end
        end
    end

    // Grant lifecycle: decide in IDLE, hold in GRANT, one dead cycle in GAP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_rr_ptr     <= 3'd0;
            r_hold_cnt   <= 8'd0;
            r_grant      <= 7'd0;
            r_grant_id   <= 3'd0;
            r_grant_prio <= 8'd0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                r_age[i] <= 4'd0;
            end
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (req != 7'd0) begin
                        r_grant      <= 7'd1 << w_win;
                        r_grant_id   <= w_win;
                        r_grant_prio <= w_max;
                        r_busy       <= 1'b1;
                        r_hold_cnt   <= 8'd0;
                        r_rr_ptr     <= (w_win == 3'd6) ? 3'd0 : (w_win + 3'd1);
                        r_state      <= c_GRANT;
                        for (int i = 0; i < 7; i++) begin
                            if (3'(i) == w_win) begin
                                r_age[i] <= 4'd0;
                            end else if (req[i]) begin
                                if (r_age[i] != 4'd15) begin
                                    r_age[i] <= r_age[i] + 4'd1;
                                end
                            end else begin
                                r_age[i] <= 4'd0;
                            end
                        end
                    end
                end
                c_GRANT: begin
                    if (done) begin
                        r_grant <= 7'd0;
                        r_busy  <= 1'b0;
                        r_state <= c_GAP;
                    end else if (r_hold_cnt == c_HOLD_LAST) begin
                        r_grant   <= 7'd0;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= c_GAP;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                c_GAP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign grant      = r_grant;
    assign grant_id   = r_grant_id;
    assign grant_prio = r_grant_prio;
    assign busy       = r_busy;
    assign timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_max_prio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_max_prio_arbiter
//  Description : Directed self-checking bench for max_prio_arbiter with
//                hand-computed expected grants, priorities and timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_max_prio_arbiter;

    logic       clk;
    logic       rst;
    logic [6:0] req;
    logic [7:0] p [0:6];
    logic       done;
    logic [6:0] grant;
    logic [2:0] grant_id;
    logic [7:0] grant_prio;
    logic       busy;
    logic       timeout;

    int n_cmp;
    int n_err;

    max_prio_arbiter #(
        .MAX_HOLD  (16),
        .AGE_SHIFT (2)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .prio0      (p[0]),
        .prio1      (p[1]),
        .prio2      (p[2]),
        .prio3      (p[3]),
        .prio4      (p[4]),
        .prio5      (p[5]),
        .prio6      (p[6]),
        .done       (done),
        .grant      (grant),
        .grant_id   (grant_id),
        .grant_prio (grant_prio),
        .busy       (busy),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_prio(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                            input logic [7:0] a3, input logic [7:0] a4, input logic [7:0] a5,
                            input logic [7:0] a6);
        p[0] = a0; p[1] = a1; p[2] = a2; p[3] = a3; p[4] = a4; p[5] = a5; p[6] = a6;
    endtask

    // Decision edge, check winner, done in first GRANT cycle, GAP, back to IDLE
    task automatic one_grant(input string tag, input logic [2:0] exp_id, input logic [7:0] exp_pr);
        step();
        chk({tag, "_id"},   32'(grant_id),   32'(exp_id));
        chk({tag, "_gnt"},  32'(grant),      32'(7'd1 << exp_id));
        chk({tag, "_prio"}, 32'(grant_prio), 32'(exp_pr));
        done = 1'b1;
        step();
        chk({tag, "_gap"},  32'({busy, grant}), 32'd0);
        done = 1'b0;
        step();
        chk({tag, "_idle"}, 32'(grant), 32'd0);
    endtask

    logic [2:0] tie_ids [0:3];
    logic [7:0] tie_pr  [0:3];
    logic [2:0] age_ids [0:3];
    logic [7:0] age_pr  [0:3];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        req   = 7'd0;
        done  = 1'b0;
        set_prio(0, 0, 0, 0, 0, 0, 0);

        tie_ids = '{3'd1, 3'd2, 3'd1, 3'd2};
        tie_pr  = '{8'd50, 8'd54, 8'd54, 8'd54};
        age_ids = '{3'd0, 3'd0, 3'd0, 3'd1};
        age_pr  = '{8'd100, 8'd100, 8'd100, 8'd102};

        // Reset values
        @(negedge clk);
        chk("rst_vals", 32'({grant, grant_id, grant_prio, busy, timeout}), 32'd0);
        rst = 1'b0;

        // Max select across all seven requesters
        set_prio(10, 50, 200, 20, 0, 0, 255);
        req = 7'h7F;
        step();
        chk("max_gnt",  32'(grant),      32'h40);
        chk("max_id",   32'(grant_id),   32'd6);
        chk("max_prio", 32'(grant_prio), 32'd255);
        chk("max_busy", 32'(busy),       32'd1);

        // Tie between requesters 1 and 2 alternates
        req = 7'd0;
        set_prio(0, 50, 50, 0, 0, 0, 0);
        do_reset();
        req = 7'b0000110;
        for (int i = 0; i < 4; i++) begin
            one_grant($sformatf("tie%0d", i), tie_ids[i], tie_pr[i]);
        end

        // Aging lets the lower priority requester win the fourth decision
        req = 7'd0;
        set_prio(100, 90, 0, 0, 0, 0, 0);
        do_reset();
        req = 7'b0000011;
        for (int i = 0; i < 4; i++) begin
            one_grant($sformatf("age%0d", i), age_ids[i], age_pr[i]);
        end

        // Timeout after exactly 16 visible grant cycles
        req = 7'd0;
        set_prio(0, 0, 0, 7, 0, 0, 0);
        do_reset();
        req = 7'b0001000;
        step();
        req = 7'd0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("to_hold%0d", i), 32'({timeout, grant}), 32'h08);
            step();
        end
        chk("to_gap_gnt", 32'({busy, grant}), 32'd0);
        chk("to_pulse",   32'(timeout),       32'd1);
        step();
        chk("to_pulse_end", 32'(timeout), 32'd0);

        // done on the 16th cycle beats the timeout
        do_reset();
        req = 7'b0001000;
        step();
        req = 7'd0;
        for (int i = 0; i < 15; i++) begin
            step();
        end
        chk("dt_last_cycle", 32'(grant), 32'h08);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("dt_released", 32'(grant),   32'd0);
        chk("dt_no_to",    32'(timeout), 32'd0);
        step();
        chk("dt_no_to2",   32'(timeout), 32'd0);

        // done in IDLE is ignored; owner dropping req does not release
        do_reset();
        done = 1'b1;
        step();
        step();
        chk("ign_idle", 32'({busy, grant, timeout}), 32'd0);
        done = 1'b0;
        set_prio(0, 9, 0, 0, 0, 0, 0);
        req = 7'b0000010;
        step();
        chk("ign_gnt", 32'(grant), 32'h02);
        req = 7'd0;
        step();
        step();
        step();
        chk("ign_persist", 32'({busy, grant}), 32'h82);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("ign_release", 32'({busy, grant}), 32'd0);

        // Asynchronous reset mid-GRANT, then a fresh decision
        set_prio(0, 0, 5, 0, 0, 0, 0);
        req = 7'b0000100;
        step();
        step();
        chk("ar_gnt", 32'(grant), 32'h04);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_drop", 32'({grant, grant_id, grant_prio, busy, timeout}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 7'b0000001;
        step();
        chk("ar_regrant", 32'(grant), 32'h01);
        chk("ar_prio",    32'(grant_prio), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
